// File: rtl/tanh_stream_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tanh_stream_driver : valid/ready front and back end for the tanh pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
module tanh_stream_driver #(
  parameter int BITWIDTH   = 18,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  output logic [BITWIDTH-1:0] act_operand,
  input  logic [BITWIDTH-1:0] act_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                busy,
  output logic [31:0]         sample_count
);

  localparam int c_addr_w   = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w    = c_addr_w + 1;
  localparam int c_credit_w = $clog2(FIFO_DEPTH + LATENCY + 1);

  logic                  r_released;
  logic [LATENCY-1:0]    r_valid_pipe;
  logic [BITWIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]   r_wr_ptr;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_credit_w-1:0] w_inflight;
  logic [c_credit_w-1:0] w_credit_used;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;

  assign w_issue = in_valid && in_ready;
  assign w_push  = r_valid_pipe[LATENCY-1];
  assign w_pop   = out_valid && out_ready;

  // Credit counts every sample already owed a FIFO slot, so a result is never refused.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + c_credit_w'(r_valid_pipe[i]);
    end
    w_credit_used = c_credit_w'(r_count) + w_inflight;
    in_ready      = r_released && (w_credit_used < c_credit_w'(FIFO_DEPTH));
  end

  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign busy      = (r_valid_pipe != '0) || (r_count != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_released  <= 1'b0;
      act_operand <= '0;
    end else begin
      r_released <= 1'b1;
      if (w_issue) begin
        act_operand <= in_data;
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_pipe_single
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_valid_pipe <= '0;
        end else begin
          r_valid_pipe <= w_issue;
        end
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_valid_pipe <= '0;
        end else begin
          r_valid_pipe <= {r_valid_pipe[LATENCY-2:0], w_issue};
        end
      end
    end
  endgenerate

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= act_result;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      sample_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + c_addr_w'(1);
        sample_count <= sample_count + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tanh_stream_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tanh_stream_driver : directed bench with an inverting tanh stand-in
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tanh_stream_driver;

  localparam int BITWIDTH   = 18;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic [BITWIDTH-1:0] act_operand;
  logic [BITWIDTH-1:0] act_result;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_data;
  logic                busy;
  logic [31:0]         sample_count;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [BITWIDTH-1:0] exp_q [$];

  always #5 clock = ~clock;

  tanh_stream_driver #(
    .BITWIDTH  (BITWIDTH),
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .act_operand (act_operand),
    .act_result  (act_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .sample_count(sample_count)
  );

  // act_operand is the first of LATENCY registers; the rest live here.
  logic [BITWIDTH-1:0] stub_q [LATENCY-1];
  always @(posedge clock) begin
    stub_q[0] <= ~act_operand;
    for (int i = 1; i < LATENCY - 1; i++) stub_q[i] <= stub_q[i-1];
  end
  assign act_result = stub_q[LATENCY-2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(posedge clock) begin
    if (reset && dut.r_valid_pipe[LATENCY-1] && (dut.r_count == FIFO_DEPTH))
      chk("push_while_full", 32'd1, 32'd0);
  end

  // One clock: account for both handshakes about to fire, then step to the next negedge.
  task automatic cycle();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      pops++;
    end
    if (in_valid && in_ready) exp_q.push_back(~in_data);
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    int acc;
    int p0;
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 18'h00155;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);

    // Reset behaviour and release
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_act_operand", 32'(act_operand), 32'd0);
    chk("rst_sample_count", sample_count, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    chk("pre_edge_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    chk("post_release_in_ready", 32'(in_ready), 32'd1);
    chk("post_release_operand", 32'(act_operand), 32'd0);
    in_valid = 1'b0;
    @(negedge clock);

    // Single operand latency
    in_valid  = 1'b1;
    in_data   = 18'h01000;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      chk("lat_early_valid", 32'(out_valid), 32'd0);
      cycle();
    end
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h3EFFF);
    cycle();
    chk("single_count", sample_count, 32'd1);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back stream
    p0 = pops;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = BITWIDTH'(i);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      cycle();
    end
    drain(30);
    chk("b2b_pops", 32'(pops - p0), 32'd16);

    // Backpressure fill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int n = 0; n < 14; n++) begin
      in_data = BITWIDTH'(100 + n);
      if (in_ready) acc++;
      cycle();
    end
    chk("bp_accepted", 32'(acc), 32'd8);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_fifo_count", 32'(dut.r_count), 32'd8);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    drain(40);
    chk("bp_ready_back", 32'(in_ready), 32'd1);

    // Full FIFO, then simultaneous pop and refill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int n = 0; n < 20 && in_ready; n++) begin
      in_data = BITWIDTH'(150 + n);
      cycle();
    end
    in_valid = 1'b0;
    repeat (LATENCY + 1) cycle();
    chk("full_count", 32'(dut.r_count), 32'd8);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int n = 0; n < 24; n++) begin
      in_data = BITWIDTH'(200 + 7 * n);
      cycle();
    end
    drain(40);
    chk("sample_count_total", sample_count, 32'(pops));

    // Mid-cycle reset with work in flight
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      in_data  = BITWIDTH'(300 + n);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("pre_rst_buffered", 32'(dut.r_count), 32'd2);
    chk("pre_rst_inflight", 32'($countones(dut.r_valid_pipe)), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    pops = 0;
    @(negedge clock);
    @(negedge clock);
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      chk("stale_out", 32'(out_valid), 32'd0);
      cycle();
    end
    chk("post_rst_count", sample_count, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
